// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the arbiter FSM state type for the memory
// arbiter codebase slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_ADDR = 2'd1;
  localparam arb_state_t ST_DATA = 2'd2;

endpackage

// File: rtl/ahb_mem.sv
// 16-word AHB-Lite slave memory with per-transfer wait-state count and ERROR
// injection inputs, latched together with the address phase.
module ahb_mem
  import ahb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [DW-1:0] hwdata,
  input  logic          hreadyin,
  input  logic [1:0]    wait_cfg,
  input  logic          err_inj,
  output logic [DW-1:0] hrdata,
  output logic          hreadyout,
  output logic [1:0]    hresp
);

  logic [DW-1:0] mem [16];
  logic          active;
  logic          wr_q;
  logic          err_q;
  logic [3:0]    idx_q;
  logic [1:0]    wcnt;
  logic          last;
  logic          unused_ok;

  assign unused_ok = ^{haddr[AW-1:6], haddr[1:0], htrans[0]};
  assign last      = active && (wcnt == '0);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      active <= 1'b0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      idx_q  <= '0;
      wcnt   <= '0;
    end else begin
      if (active) begin
        if (wcnt != '0) begin
          wcnt <= wcnt - 2'd1;
        end else begin
          active <= 1'b0;
        end
      end
      if (hsel && htrans[1] && hreadyin && hreadyout) begin
        active <= 1'b1;
        wr_q   <= hwrite;
        idx_q  <= haddr[5:2];
        wcnt   <= wait_cfg;
        err_q  <= err_inj;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset && last && wr_q && !err_q) begin
      mem[idx_q] <= hwdata;
    end
  end

  assign hreadyout = !active || (wcnt == '0);
  assign hresp     = (last && err_q) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = (active && !wr_q) ? mem[idx_q] : '0;

endmodule

// File: rtl/ahb_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester the pointer prefers, and the pointer moves away from whoever was served.
module ahb_rr_arb2 (
  input  logic       hclk,
  input  logic       hreset,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       served,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic ptr;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ptr <= 1'b0;
    end else if (adv) begin
      ptr <= ~served;
    end
  end

  always_comb begin
    gnt_vld = |req;
    gnt_id  = ptr;
    if (req == 2'b01) begin
      gnt_id = 1'b0;
    end else if (req == 2'b10) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_mem_arb.sv
// Arbitrates two simple request/done ports onto one AHB-Lite master issuing
// SINGLE word transfers through an IDLE -> ADDR -> DATA sequence.
module ahb_mem_arb
  import ahb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          hsel,
  output logic          hwrite,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [DW-1:0] hwdata,
  input  logic [DW-1:0] hrdata,
  input  logic          hreadyout,
  input  logic [1:0]    hresp
);

  arb_state_t    state;
  logic          cur_id;
  logic [DW-1:0] wdata_q;
  logic          gnt_vld;
  logic          gnt_id;
  logic          xfer_done;
  logic          resp_err;

  assign xfer_done = (state == ST_DATA) && hreadyout;
  assign resp_err  = (hresp == HRESP_ERROR);

  ahb_rr_arb2 u_arb (
    .hclk    (hclk),
    .hreset  (hreset),
    .req     ({req1, req0}),
    .adv     (xfer_done),
    .served  (cur_id),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state  <= ST_IDLE;
      cur_id <= 1'b0;
      haddr  <= '0;
      hwrite <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            state  <= ST_ADDR;
            cur_id <= gnt_id;
            haddr  <= gnt_id ? addr1 : addr0;
            hwrite <= gnt_id ? we1 : we0;
          end
        end
        ST_ADDR: begin
          if (hreadyout) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Completion: the request ports are not looked at again, so a
          // requester dropping req mid-transfer cannot abort it.
          if (hreadyout) begin
            state <= ST_IDLE;
            done0 <= ~cur_id;
            done1 <= cur_id;
            err0  <= ~cur_id & resp_err;
            err1  <= cur_id & resp_err;
            if (!hwrite) begin
              rdata <= hrdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write data is only visible on the bus through the DATA-state gate below.
  always_ff @(posedge hclk) begin
    if ((state == ST_IDLE) && gnt_vld) begin
      wdata_q <= gnt_id ? wdata1 : wdata0;
    end
  end

  assign hsel   = (state == ST_ADDR);
  assign htrans = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsize  = HSIZE_WORD;
  assign hburst = HBURST_SINGLE;
  assign hwdata = ((state == ST_DATA) && hwrite) ? wdata_q : '0;

endmodule

// File: tb/tb_ahb_mem_arb.sv
// Bench for ahb_mem_arb attached to the ahb_mem slave: table of single
// transfers plus hand-written arbitration, reset and req-drop sequences.
module tb_ahb_mem_arb;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        done0, done1, err0, err1;
  logic [31:0] rdata, haddr, hwdata, hrdata;
  logic        hsel, hwrite, hreadyout;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;
  logic [1:0]  wait_cfg = '0;
  logic        err_inj = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          id;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;
  exp_t sbq[$];
  exp_t e_mon;

  typedef struct {
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    bit          einj;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;
  vec_t tv[7];

  always #5 hclk = ~hclk;

  ahb_mem_arb #(.AW(32), .DW(32)) dut (
    .hclk(hclk), .hreset(hreset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1), .rdata(rdata),
    .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
  );

  ahb_mem #(.AW(32), .DW(32)) u_mem (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hreadyin(1'b1),
    .wait_cfg(wait_cfg), .err_inj(err_inj),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit id, input bit err, input bit chk_rd, input logic [31:0] rd);
    exp_t e;
    e.id = id; e.err = err; e.chk_rd = chk_rd; e.rd = rd;
    sbq.push_back(e);
  endtask

  // Scoreboard: every done pulse is matched against the oldest expectation.
  always @(negedge hclk) begin
    chk("done_exclusive", {31'b0, done0 & done1}, 32'd0);
    if (done0 || done1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", {30'b0, done1, done0}, 32'd0);
      end else begin
        e_mon = sbq.pop_front();
        chk("done_id", {31'b0, done1}, {31'b0, e_mon.id});
        chk("done_err", {31'b0, done1 ? err1 : err0}, {31'b0, e_mon.err});
        if (e_mon.chk_rd) chk("rdata", rdata, e_mon.rd);
      end
    end
  end

  task automatic do_xfer(input bit id, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wait_n, input bit einj,
                         input int exp_lat, input bit chk_bus);
    int lat;
    bit got;
    @(posedge hclk); #1;
    if (id) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else    begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; end
    wait_cfg = 2'(wait_n);
    err_inj  = einj;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge hclk); #1;
      lat++;
      got = id ? done1 : done0;
      if (chk_bus && !got) begin
        if (lat == 1) begin
          chk("addr_hsel", {31'b0, hsel}, 32'd1);
          chk("addr_htrans", {30'b0, htrans}, 32'd2);
          chk("addr_hwrite", {31'b0, hwrite}, {31'b0, we});
        end else begin
          chk("data_hsel", {31'b0, hsel}, 32'd0);
          chk("data_htrans", {30'b0, htrans}, 32'd0);
          chk("data_hwdata", hwdata, we ? wdata : 32'd0);
        end
        chk("haddr_stable", haddr, addr);
      end
    end
    if (id) req1 = 0; else req0 = 0;
    wait_cfg = '0;
    err_inj  = 1'b0;
    chk("xfer_timeout", {31'b0, got}, 32'd1);
    chk("latency", lat, exp_lat);
  endtask

  initial begin
    int n;
    int cyc;
    int n0;
    bit got;

    //          id we addr    wdata         wt inj eerr exp_rd        lat
    tv[0] = '{0, 1, 32'h04, 32'h11223344, 0, 0, 0, 32'h0,        3};
    tv[1] = '{1, 0, 32'h04, 32'h0,        0, 0, 0, 32'h11223344, 3};
    tv[2] = '{0, 1, 32'h0C, 32'hDEADBEEF, 2, 0, 0, 32'h0,        5};
    tv[3] = '{1, 0, 32'h0C, 32'h0,        0, 1, 1, 32'h0,        3};
    tv[4] = '{1, 1, 32'h20, 32'hA5A50F0F, 1, 0, 0, 32'h0,        4};
    tv[5] = '{0, 0, 32'h20, 32'h0,        1, 0, 0, 32'hA5A50F0F, 4};
    tv[6] = '{0, 0, 32'h0C, 32'h0,        0, 0, 0, 32'hDEADBEEF, 3};

    // Reset state
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_hsel", {31'b0, hsel}, 32'd0);
    chk("rst_htrans", {30'b0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", {31'b0, hwrite}, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", {28'b0, done0, done1, err0, err1}, 32'd0);
    chk("rst_hsize", {29'b0, hsize}, 32'd2);
    chk("rst_hburst", {29'b0, hburst}, 32'd0);
    hreset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      push(tv[i].id, tv[i].exp_err, !tv[i].we && !tv[i].exp_err, tv[i].exp_rd);
      do_xfer(tv[i].id, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].wait_n,
              tv[i].einj, tv[i].exp_lat, 1'b1);
    end

    // Reset during ADDR; the pointer currently prefers requester 1.
    @(posedge hclk); #1;
    req1 = 1; we1 = 0; addr1 = 32'h04;
    @(posedge hclk); #1;
    chk("pre_rst_hsel", {31'b0, hsel}, 32'd1);
    hreset = 1'b1;
    req1 = 0;
    @(posedge hclk); #1;
    chk("midrst_hsel", {31'b0, hsel}, 32'd0);
    chk("midrst_htrans", {30'b0, htrans}, 32'd0);
    chk("midrst_done", {30'b0, done1, done0}, 32'd0);
    hreset = 1'b0;

    // Simultaneous requests after reset: requester 0 must win.
    push(0, 0, 0, 32'h0);
    push(1, 0, 0, 32'h0);
    fork
      do_xfer(0, 1, 32'h00, 32'hCAFE0000, 0, 0, 3, 1'b1);
      do_xfer(1, 1, 32'h08, 32'h0000BEEF, 0, 0, 6, 1'b0);
    join
    push(0, 0, 1, 32'h0000BEEF);
    do_xfer(0, 0, 32'h08, 32'h0, 0, 0, 3, 1'b1);
    push(1, 0, 1, 32'hCAFE0000);
    do_xfer(1, 0, 32'h00, 32'h0, 0, 0, 3, 1'b1);

    // Both requests held for four transfers: grants 0,1,0,1.
    push(0, 0, 0, 32'h0);
    push(1, 0, 0, 32'h0);
    push(0, 0, 0, 32'h0);
    push(1, 0, 0, 32'h0);
    @(posedge hclk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h14; wdata0 = 32'h01010101;
    req1 = 1; we1 = 1; addr1 = 32'h18; wdata1 = 32'h02020202;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(posedge hclk); #1;
      cyc++;
      if (done0 || done1) n++;
    end
    req0 = 0;
    req1 = 0;
    chk("rr_count", n, 4);
    chk("rr_cycles", cyc, 12);

    // req0 pulsed only while requester 1 is in ADDR: never served.
    push(1, 0, 1, 32'h01010101);
    @(posedge hclk); #1;
    req1 = 1; we1 = 0; addr1 = 32'h14;
    @(posedge hclk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'h77777777;
    @(posedge hclk); #1;
    req0 = 0;
    n0 = 0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (done0) n0++;
      if (done1) begin got = 1; req1 = 0; end
      @(posedge hclk); #1;
    end
    chk("drop_pre_done1", {31'b0, got}, 32'd1);
    chk("drop_pre_no_done0", n0, 0);

    // req0 dropped right after grant: transfer still completes.
    push(0, 0, 0, 32'h0);
    @(posedge hclk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h24; wdata0 = 32'h5A5A1234;
    @(posedge hclk); #1;
    req0 = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge hclk); #1;
      got = done0;
    end
    chk("drop_post_done0", {31'b0, got}, 32'd1);
    push(1, 0, 1, 32'h5A5A1234);
    do_xfer(1, 0, 32'h24, 32'h0, 0, 0, 3, 1'b1);

    repeat (4) @(posedge hclk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_mem_arb.md
AHB_MEM_ARB -- requirements
Module: ahb_mem_arb

Interface
REQ-001 Parameter AW, default 32, AHB address width.
REQ-002 Parameter DW, default 32, AHB data width (DW=32 only; hsize fixed 3'b010).
REQ-003 hclk  input  1  single clock; all logic on rising edge.
REQ-004 hreset  input  1  synchronous, active-high reset.
REQ-005 req0/req1  input  1 each  requester transfer request, held high until own done pulse.
REQ-006 we0/we1  input  1 each  1=write, 0=read; stable while req high.
REQ-007 addr0/addr1  input  AW each  byte address; stable while req high.
REQ-008 wdata0/wdata1  input  DW each  write data; stable while req high.
REQ-009 done0/done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-010 err0/err1  output  1 each  valid with done; 1 when slave returned hresp=ERROR.
REQ-011 rdata  output  DW  read data, valid in the done cycle, shared by both requesters.
REQ-012 hsel, hwrite  output  1 each  AHB slave select and direction.
REQ-013 haddr  output  AW; htrans  output  2; hsize  output  3; hburst  output  3  (hburst always SINGLE).
REQ-014 hwdata  output  DW  AHB write data, driven in the data phase.
REQ-015 hrdata  input  DW; hreadyout  input  1; hresp  input  2  slave response signals.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR and DATA.
REQ-017 In IDLE, when any req is high, the arbiter SHALL select a winner, latch its we/addr/wdata and enter ADDR on the next edge.
REQ-018 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the preferred requester; after each done it points to the other requester.
REQ-019 When only one req is high, that requester wins regardless of the pointer.
REQ-020 In ADDR: hsel=1, htrans=NONSEQ, haddr/hwrite from the latched request; on an edge with hreadyout=1 go to DATA, otherwise hold ADDR with all outputs stable.
REQ-021 In DATA: htrans=IDLE, hsel=0, and hwdata=latched wdata for writes.
REQ-022 DATA SHALL wait for hreadyout=1; on that edge, done and err pulse for the winner, rdata captures hrdata on reads, and the FSM returns to IDLE.
REQ-023 err SHALL be 1 iff hresp=ERROR (2'b01) in the completing cycle; other hresp values are treated as OKAY.
REQ-024 Minimum latency SHALL be 3 cycles from req high to the done pulse, with one cycle of IDLE gap between back-to-back transfers.
REQ-025 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the transfer.
REQ-026 If both reqs rise together in IDLE, the pointer SHALL decide, and the loser is served next with no starvation.
REQ-027 done0 and done1 SHALL never both be high in the same cycle.
REQ-028 Outside ADDR, htrans SHALL be IDLE and hsel SHALL be 0; hsize=3'b010 and hburst=SINGLE at all times.

Reset
REQ-029 While hreset=1 at a clock edge, the block SHALL enter IDLE and clear the pointer to requester 0.
REQ-030 Reset SHALL drive all outputs to 0 (hsel, haddr, hwrite, htrans=IDLE, hwdata, done, err, rdata); hsize stays 3'b010.
REQ-031 Reset mid-transfer SHALL abandon the transfer without asserting done.

Structure
REQ-032 The shared package ahb_pkg SHALL hold the HTRANS (IDLE/BUSY/NONSEQ/SEQ), HRESP (OKAY/ERROR/RETRY/SPLIT) and HBURST (SINGLE..INCR16) encodings plus the FSM state type.
REQ-033 A single sub-module, ahb_rr_arb2, SHALL implement the 2-way round-robin grant; the FSM and AHB drive remain in ahb_mem_arb.
REQ-034 The bench SHALL connect ahb_mem_arb to ahb_mem with hreadyin tied to 1.

Verification
REQ-035 Write via req0 (addr 0x04, data 0x11223344), then read via req1 (addr 0x04) -> done1 with rdata=0x11223344 and err1=0.
REQ-036 req0 and req1 rise together (writes to 0x00 and 0x08) -> done0 first, then done1, each completing in 3 cycles with a 1-cycle gap.
REQ-037 Both reqs held continuously for 4 transfers -> grants alternate 0,1,0,1 with no starvation.
REQ-038 Slave model holds hreadyout=0 for 2 cycles in DATA -> done is delayed by 2 cycles and hwdata and haddr stay stable.
REQ-039 hresp=ERROR injected on a read of 0x0C -> done and err pulse together for that requester and the FSM returns to IDLE.
REQ-040 hreset asserted during ADDR -> next cycle hsel=0, htrans=IDLE, no done pulse, and the pointer reads 0.
